// File: rtl/pipe_pkg.sv
// Shared definitions for the stream/pipeline blocks.
//   skid_state_t : occupancy state of a 2-entry skid buffer
//   SKID_DEPTH   : number of beats a skid buffer can hold
package pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buffer.sv
// Valid/ready register slice with a registered backward path.
// A main register holds the head beat and a skid register catches the one
// beat that can arrive in the cycle out_ready drops. Every output is decoded
// from the state flop or taken straight from main_q, so in_ready has no
// combinational path from out_ready.
//   clk, rst_n           : clock, async active-low reset
//   in_valid_i/in_ready_o/in_data_i    : upstream handshake + payload
//   out_valid_o/out_ready_i/out_data_o : downstream handshake + payload
//   occupancy_o          : held beats (0..2)
module skid_buffer
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [1:0]            occupancy_o
);

  skid_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_fire, out_fire;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_d = SKID_BUSY;
          main_d  = in_data_i;
        end
      end
      SKID_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data_i;
        end else if (in_fire) begin
          // head is stalled: park the new beat behind it
          state_d = SKID_FULL;
          skid_d  = in_data_i;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          state_d = SKID_BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SKID_EMPTY;
    else        state_q <= state_d;
  end

  // payload registers carry no reset; out_data is only meaningful with out_valid
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  always_comb begin
    out_valid_o = 1'b0;
    in_ready_o  = 1'b1;
    occupancy_o = 2'd0;
    case (state_q)
      SKID_BUSY: begin
        out_valid_o = 1'b1;
        occupancy_o = 2'd1;
      end
      SKID_FULL: begin
        out_valid_o = 1'b1;
        in_ready_o  = 1'b0;
        occupancy_o = 2'(SKID_DEPTH);
      end
      default: ;
    endcase
  end

  assign out_data_o = main_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Directed and scoreboarded random checks for skid_buffer.
module tb_skid_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  occ;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  skid_buffer #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .occupancy_o (occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // posedges land at t%10==5; out of reset, in_ready may only move there
  always @(in_ready) if (rst_n) chk("rdy_at_edge", 32'($time % 10), 32'd5);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic st(input string tag, input logic v, input logic r, input logic [1:0] o);
    chk({tag, "_ov"}, 32'(out_valid), 32'(v));
    chk({tag, "_ir"}, 32'(in_ready), 32'(r));
    chk({tag, "_occ"}, 32'(occ), 32'(o));
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_d, prev_d;
  logic        prev_stall;
  int          pushed, cyc;
  bit          fi, fo;

  initial begin
    in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b0;
    // reset held with in_valid=1: nothing captured
    step(); step();
    st("rst", 1'b0, 1'b1, 2'd0);
    #3 rst_n = 1'b1;
    step();
    st("first", 1'b1, 1'b1, 2'd1);
    chk("first_data", out_data, 32'hA5);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    st("drain0", 1'b0, 1'b1, 2'd0);

    // backpressure fill
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    step(); st("bp1", 1'b1, 1'b1, 2'd1);
    in_data = 32'h22;
    step(); st("bp2", 1'b1, 1'b0, 2'd2);
    chk("bp2_data", out_data, 32'h11);
    in_data = 32'h33;
    step(); st("bp_hold", 1'b1, 1'b0, 2'd2);
    chk("bp_hold_data", out_data, 32'h11);
    out_ready = 1'b1;
    step(); st("bp_o1", 1'b1, 1'b1, 2'd1);
    chk("bp_d22", out_data, 32'h22);
    step(); st("bp_o2", 1'b1, 1'b1, 2'd1);
    chk("bp_d33", out_data, 32'h33);
    in_valid = 1'b0;
    step(); st("bp_empty", 1'b0, 1'b1, 2'd0);

    // full-rate stream
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'(i);
      step();
      st("fr", 1'b1, 1'b1, 2'd1);
      chk("fr_data", out_data, 32'(i));
    end
    in_valid = 1'b0;
    step(); st("fr_end", 1'b0, 1'b1, 2'd0);

    // ready decoupling in FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    step(); in_data = 32'h2;
    step(); in_valid = 1'b0;
    st("dc_full", 1'b1, 1'b0, 2'd2);
    #2 out_ready = 1'b1;
    #2 chk("dc_mid_ir", 32'(in_ready), 32'd0);
    step();
    st("dc_after", 1'b1, 1'b1, 2'd1);
    chk("dc_data", out_data, 32'h2);
    step(); st("dc_empty", 1'b0, 1'b1, 2'd0);

    // reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD;
    step(); in_data = 32'hBEEF;
    step(); in_valid = 1'b0;
    st("rf_full", 1'b1, 1'b0, 2'd2);
    #2 rst_n = 1'b0;
    #1 st("rf_async", 1'b0, 1'b1, 2'd0);
    in_valid = 1'b1; in_data = 32'h1234;
    step(); st("rf_inrst", 1'b0, 1'b1, 2'd0);
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h77;
    step();
    st("rf_post", 1'b1, 1'b1, 2'd1);
    chk("rf_post_data", out_data, 32'h77);
    in_valid = 1'b0; out_ready = 1'b1;
    step(); st("rf_empty", 1'b0, 1'b1, 2'd0);

    // random traffic against a scoreboard
    q.delete(); pushed = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0;
    while ((pushed < 2000 || q.size() != 0) && cyc < 20000) begin
      in_valid  = (pushed < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_occ", 32'(occ), 32'(q.size()));
      if (prev_stall && out_valid) chk("rnd_stable", out_data, prev_d);
      fi = in_valid & in_ready;
      fo = out_valid & out_ready;
      if (fo) begin
        exp_d = (q.size() != 0) ? q.pop_front() : 32'hFFFF_FFFF;
        chk("rnd_data", out_data, exp_d);
      end
      if (fi) begin q.push_back(in_data); pushed++; end
      prev_stall = out_valid & ~out_ready;
      prev_d     = out_data;
      step();
      cyc++;
    end
    chk("rnd_pushed", 32'(pushed), 32'd2000);
    chk("rnd_left", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
- Valid/ready register slice that registers the backward (ready) path as well as the forward (valid/data) path.
- in_ready comes only from flops, so it has no combinational dependency on out_ready. out_valid and out_data also come only from flops.
- Sustains one beat per cycle with a 2-entry store (main + skid).
- Inserted between stream stages wherever a long out_ready path limits timing, or together with pipeline_reg stages.

Parameters:
- DATA_WIDTH, 32, payload width in bits.

Ports:
- clk  input  1  clock, all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  buffer can accept a beat; driven from state flops only.
- in_data  input  DATA_WIDTH  upstream payload.
- out_valid  output  1  downstream beat valid; driven from state flops only.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_WIDTH  downstream payload; driven directly from the main data register.
- occupancy  output  2  number of held beats (0..2), for debug and performance counters.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - main_q (DATA_WIDTH) always holds the head beat when out_valid=1.
  - skid_q (DATA_WIDTH) holds the second beat, and is valid only in state FULL.
- Data registers are not reset. out_data is don't-care while out_valid=0 and must not be checked then.
- State machine, states EMPTY, BUSY, FULL:
  - EMPTY: out_valid=0, in_ready=1, occupancy=0.
  - BUSY: out_valid=1, in_ready=1, occupancy=1.
  - FULL: out_valid=1, in_ready=0, occupancy=2.
- Transitions from EMPTY:
  - in_fire -> BUSY; main_q <= in_data.
  - Otherwise, stay in EMPTY.
- Transitions from BUSY:
  - in_fire & out_fire -> BUSY; main_q <= in_data.
  - in_fire & !out_fire -> FULL; skid_q <= in_data; main_q unchanged.
  - !in_fire & out_fire -> EMPTY.
  - Neither -> BUSY, all registers held.
- Transitions from FULL:
  - out_fire -> BUSY; main_q <= skid_q.
  - Otherwise, stay in FULL.
  - in_fire cannot occur in FULL because in_ready=0.
- Latency: a beat accepted at edge N is presented on out_valid/out_data from edge N, i.e. visible in cycle N+1. Minimum latency is 1 cycle.
- Throughput: with in_valid and out_ready both held at 1, the buffer stays in BUSY and moves 1 beat/cycle.
- Ordering: strict FIFO. No beat is lost or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data is held stable.
- Decoupling: in_ready for the next cycle depends on this cycle's out_ready; in_ready in the same cycle does not. Toggling out_ready mid-cycle never changes in_ready in that cycle.
- Upstream obligation: in_valid/in_data may change freely while in_ready=0. Nothing is captured while in_ready=0.
- Reset:
  - On asserting rst_n, state=EMPTY immediately, independent of the clock.
  - Values during reset: out_valid=0, in_ready=1, occupancy=0.
  - Reset in any state, including FULL, discards held beats.
  - No in_fire is recognised while rst_n=0.
  - First acceptance is possible on the first rising edge after rst_n deasserts.
- Illegal state encodings recover to EMPTY (default branch).

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] skid_state_t {SKID_EMPTY, SKID_BUSY, SKID_FULL}.
  - localparam SKID_DEPTH = 2.
- pipe_pkg is reused by later stream blocks for their occupancy reporting.
- No sub-module: two data registers plus a 3-state FSM in one module. occupancy, in_ready and out_valid are decoded from the state register.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0. After release, first edge with in_valid=1, in_data=0xA5 -> next cycle out_valid=1, out_data=0xA5.
- Backpressure fill: out_ready=0; push 0x11, then 0x22 -> after the 2nd edge in_ready=0 and occupancy=2. Hold 0x33 on input -> not captured. Raise out_ready -> outputs 0x11, 0x22, 0x33 in order; in_ready returns to 1 the cycle after the first out_fire.
- Full-rate stream: in_valid=out_ready=1, data 0..15 on consecutive cycles -> out_data 0..15 on consecutive cycles with 1-cycle latency; state stays BUSY and occupancy=1 throughout.
- Ready decoupling: in FULL, toggle out_ready 0->1 mid-cycle -> in_ready stays 0 until the next edge. Assert (SVA) that in_ready changes only at clk edges.
- Reset mid-FULL: hold 0xDEAD and 0xBEEF, assert rst_n asynchronously between edges -> out_valid=0 and occupancy=0 immediately. After release, the first output is the next pushed beat, never 0xDEAD or 0xBEEF.
- Random: 2000 beats with random in_valid and out_ready (each 50%) against a scoreboard queue -> no loss, duplication or reordering. out_data stable while out_valid & !out_ready.
